// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified memory port between instruction fetch (I) and the
//   MEM-stage data access (D). One transaction is outstanding at a time.
//   The FSM moves IDLE -> REQ -> WAIT -> IDLE. Arbitration happens only in
//   IDLE. D has priority unless IF has already lost STARVE_LIMIT conflicts
//   in a row. The o_m_* request fields are latched on grant and held until
//   the memory accepts the request.
//
// Ports
//   i_clk, i_rst                     clock (rising edge), async active-high reset
//   i_i_req/i_i_addr                 fetch request (level) and address
//   o_i_valid/o_i_inst/o_i_stall     fetch done pulse, instruction word, IF stall
//   i_d_req/i_d_wen/i_d_addr/i_d_wdata   data request (level), store flag, addr, data
//   o_d_valid/o_d_rdata/o_d_stall    data done pulse, load data, MEM stall
//   o_m_req/o_m_wen/o_m_addr/o_m_wdata   memory request channel
//   i_m_ready                        memory accepts the request this cycle
//   i_m_rvalid/i_m_rdata             memory response / write ack and read data
//
// Optional build macro
//   ARB_PERF_CNT_EN adds o_cnt_conflict (IDLE cycles with both ports
//   requesting) and o_cnt_wait (cycles in REQ or WAIT). Both counters
//   saturate at all-ones.

module mem_port_arbiter #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_i_req,
  input  logic [ADDR_W-1:0] i_i_addr,
  output logic              o_i_valid,
  output logic [31:0]       o_i_inst,
  output logic              o_i_stall,
  input  logic              i_d_req,
  input  logic              i_d_wen,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_valid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_stall,
  output logic              o_m_req,
  output logic              o_m_wen,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_wdata,
  input  logic              i_m_ready,
  input  logic              i_m_rvalid,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       o_cnt_conflict,
  output logic [31:0]       o_cnt_wait,
`endif
  input  logic [DATA_W-1:0] i_m_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t              state_q;
  logic                owner_d_q;     // 1: current transaction belongs to D
  logic [3:0]          starve_cnt_q;
  logic                m_req_q;
  logic                m_wen_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [DATA_W-1:0]   m_wdata_q;
  logic                i_valid_q;
  logic [31:0]         i_inst_q;
  logic                d_valid_q;
  logic [DATA_W-1:0]   d_rdata_q;

  logic eff_i;
  logic eff_d;
  logic grant_d;
  logic grant_i;

  // Effective requests and the IDLE arbitration decision.
  // A requester is masked during its own valid cycle. Its old address is
  // still on the bus then and must not be issued a second time.
  always_comb begin
    eff_i   = i_i_req & ~i_valid_q;
    eff_d   = i_d_req & ~d_valid_q;
    grant_d = eff_d & (~eff_i | (starve_cnt_q != STARVE_MAX));
    grant_i = eff_i & ~grant_d;
  end

  // Main FSM: state, owner, starvation counter and all registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      owner_d_q    <= 1'b0;
      starve_cnt_q <= 4'd0;
      m_req_q      <= 1'b0;
      m_wen_q      <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      i_valid_q    <= 1'b0;
      i_inst_q     <= 32'd0;
      d_valid_q    <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_d) begin
            state_q   <= ST_REQ;
            owner_d_q <= 1'b1;
            m_req_q   <= 1'b1;
            m_wen_q   <= i_d_wen;
            m_addr_q  <= i_d_addr;
            m_wdata_q <= i_d_wdata;
            // IF lost this conflict; the count saturates at the limit
            if (eff_i && (starve_cnt_q != STARVE_MAX)) begin
              starve_cnt_q <= starve_cnt_q + 4'd1;
            end
          end else if (grant_i) begin
            state_q      <= ST_REQ;
            owner_d_q    <= 1'b0;
            m_req_q      <= 1'b1;
            m_wen_q      <= 1'b0;
            m_addr_q     <= i_i_addr;
            m_wdata_q    <= '0;
            starve_cnt_q <= 4'd0;
          end
        end
        ST_REQ: begin
          if (i_m_ready) begin
            state_q <= ST_WAIT;
            m_req_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (i_m_rvalid) begin
            state_q <= ST_IDLE;
            if (owner_d_q) begin
              d_valid_q <= 1'b1;
              // A store ack leaves the previously loaded data in place
              if (!m_wen_q) begin
                d_rdata_q <= i_m_rdata;
              end
            end else begin
              i_valid_q <= 1'b1;
              i_inst_q  <= m_addr_q[2] ? i_m_rdata[63:32] : i_m_rdata[31:0];
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          m_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] cnt_conflict_q;
  logic [31:0] cnt_wait_q;

  // Saturating performance counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_conflict_q <= 32'd0;
      cnt_wait_q     <= 32'd0;
    end else begin
      if ((state_q == ST_IDLE) && eff_i && eff_d && (cnt_conflict_q != 32'hFFFF_FFFF)) begin
        cnt_conflict_q <= cnt_conflict_q + 32'd1;
      end
      if (((state_q == ST_REQ) || (state_q == ST_WAIT)) && (cnt_wait_q != 32'hFFFF_FFFF)) begin
        cnt_wait_q <= cnt_wait_q + 32'd1;
      end
    end
  end

  assign o_cnt_conflict = cnt_conflict_q;
  assign o_cnt_wait     = cnt_wait_q;
`endif

  assign o_i_valid = i_valid_q;
  assign o_i_inst  = i_inst_q;
  assign o_d_valid = d_valid_q;
  assign o_d_rdata = d_rdata_q;
  assign o_m_req   = m_req_q;
  assign o_m_wen   = m_wen_q;
  assign o_m_addr  = m_addr_q;
  assign o_m_wdata = m_wdata_q;

  // The stalls are combinational so that a pipeline register freezes in the
  // same cycle its stage raises a request.
  assign o_i_stall = i_i_req & ~i_valid_q;
  assign o_d_stall = i_d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [63:0] i_addr = 64'd0;
  logic        d_req = 1'b0;
  logic        d_wen = 1'b0;
  logic [63:0] d_addr = 64'd0;
  logic [63:0] d_wdata = 64'd0;
  logic        m_ready = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [63:0] m_rdata = 64'd0;
  logic        i_valid, i_stall, d_valid, d_stall, m_req, m_wen;
  logic [31:0] i_inst;
  logic [63:0] d_rdata, m_addr, m_wdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] cnt_conflict, cnt_wait;
`endif

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(64), .ADDR_W(64), .STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_i_req(i_req), .i_i_addr(i_addr),
    .o_i_valid(i_valid), .o_i_inst(i_inst), .o_i_stall(i_stall),
    .i_d_req(d_req), .i_d_wen(d_wen), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_valid(d_valid), .o_d_rdata(d_rdata), .o_d_stall(d_stall),
    .o_m_req(m_req), .o_m_wen(m_wen), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
    .i_m_ready(m_ready), .i_m_rvalid(m_rvalid),
`ifdef ARB_PERF_CNT_EN
    .o_cnt_conflict(cnt_conflict), .o_cnt_wait(cnt_wait),
`endif
    .i_m_rdata(m_rdata)
  );

  typedef struct {
    logic        i_req;
    logic [63:0] i_addr;
    logic        d_req;
    logic        d_wen;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        rdy;
    logic        rv;
    logic [63:0] rdata;
    logic        e_m_req;
    logic        e_m_wen;
    logic [63:0] e_m_addr;
    logic [63:0] e_m_wdata;
    logic        e_i_valid;
    logic [31:0] e_i_inst;
    logic        e_i_stall;
    logic        e_d_valid;
    logic [63:0] e_d_rdata;
    logic        e_d_stall;
  } vec_t;

  localparam logic [63:0] RD0 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] LD  = 64'h1122_3344_5566_7788;
  localparam logic [63:0] RD2 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] RD3 = 64'h0123_4567_89AB_CDEF;
  localparam logic [31:0] AB  = 32'hAAAA_BBBB;

  vec_t vt[21];

  function automatic vec_t mk(
    input logic ir, input logic [63:0] ia, input logic dr, input logic dw,
    input logic [63:0] da, input logic [63:0] dd, input logic rdy, input logic rv,
    input logic [63:0] rd, input logic emr, input logic emw, input logic [63:0] ema,
    input logic [63:0] emd, input logic eiv, input logic [31:0] eii, input logic eis,
    input logic edv, input logic [63:0] edr, input logic eds);
    vec_t v;
    v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_wen = dw; v.d_addr = da;
    v.d_wdata = dd; v.rdy = rdy; v.rv = rv; v.rdata = rd;
    v.e_m_req = emr; v.e_m_wen = emw; v.e_m_addr = ema; v.e_m_wdata = emd;
    v.e_i_valid = eiv; v.e_i_inst = eii; v.e_i_stall = eis;
    v.e_d_valid = edv; v.e_d_rdata = edr; v.e_d_stall = eds;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs away from the rising edge, then let stalls settle.
  task automatic drive(input logic ir, input logic [63:0] ia, input logic dr,
                       input logic dw, input logic [63:0] da, input logic [63:0] dd,
                       input logic rdy, input logic rv, input logic [63:0] rd);
    @(negedge clk);
    i_req = ir; i_addr = ia; d_req = dr; d_wen = dw; d_addr = da; d_wdata = dd;
    m_ready = rdy; m_rvalid = rv; m_rdata = rd;
    #1;
  endtask

  task automatic chk_zero(input string tag);
    n_vec++;
    chk({tag, " m_req"}, m_req, 64'd0);
    chk({tag, " m_wen"}, m_wen, 64'd0);
    chk({tag, " m_addr"}, m_addr, 64'd0);
    chk({tag, " m_wdata"}, m_wdata, 64'd0);
    chk({tag, " i_valid"}, i_valid, 64'd0);
    chk({tag, " i_inst"}, i_inst, 64'd0);
    chk({tag, " d_valid"}, d_valid, 64'd0);
    chk({tag, " d_rdata"}, d_rdata, 64'd0);
  endtask

  initial begin
    int nreq;
    int nval;
    int ival;
    string t;

    // Cycle-by-cycle table: fetch at 0x104, load, stalled store, fetch at 0x200.
    //            ir  ia        dr  dw  da          dd      rdy  rv  rd   | mreq mwen maddr     mwdata  iv  inst         is  dv  drdata is_d
    vt[0]  = mk(1'b1, 64'h104, 1'b0, 1'b0, 64'h0,    64'h0,  1'b1, 1'b1, RD0, 1'b0, 1'b0, 64'h0,    64'h0,  1'b0, 32'h0,        1'b1, 1'b0, 64'h0, 1'b0);
    vt[1]  = mk(1'b1, 64'h104, 1'b0, 1'b0, 64'h0,    64'h0,  1'b1, 1'b1, RD0, 1'b1, 1'b0, 64'h104,  64'h0,  1'b0, 32'h0,        1'b1, 1'b0, 64'h0, 1'b0);
    vt[2]  = mk(1'b1, 64'h104, 1'b0, 1'b0, 64'h0,    64'h0,  1'b1, 1'b1, RD0, 1'b0, 1'b0, 64'h104,  64'h0,  1'b0, 32'h0,        1'b1, 1'b0, 64'h0, 1'b0);
    vt[3]  = mk(1'b1, 64'h104, 1'b0, 1'b0, 64'h0,    64'h0,  1'b1, 1'b1, RD0, 1'b0, 1'b0, 64'h104,  64'h0,  1'b1, AB,           1'b0, 1'b0, 64'h0, 1'b0);
    vt[4]  = mk(1'b0, 64'h0,   1'b0, 1'b0, 64'h0,    64'h0,  1'b0, 1'b0, RD0, 1'b0, 1'b0, 64'h104,  64'h0,  1'b0, AB,           1'b0, 1'b0, 64'h0, 1'b0);
    vt[5]  = mk(1'b0, 64'h0,   1'b1, 1'b0, 64'h3000, 64'h0,  1'b1, 1'b1, LD,  1'b0, 1'b0, 64'h104,  64'h0,  1'b0, AB,           1'b0, 1'b0, 64'h0, 1'b1);
    vt[6]  = mk(1'b0, 64'h0,   1'b1, 1'b0, 64'h3000, 64'h0,  1'b1, 1'b1, LD,  1'b1, 1'b0, 64'h3000, 64'h0,  1'b0, AB,           1'b0, 1'b0, 64'h0, 1'b1);
    vt[7]  = mk(1'b0, 64'h0,   1'b1, 1'b0, 64'h3000, 64'h0,  1'b1, 1'b1, LD,  1'b0, 1'b0, 64'h3000, 64'h0,  1'b0, AB,           1'b0, 1'b0, 64'h0, 1'b1);
    vt[8]  = mk(1'b0, 64'h0,   1'b1, 1'b0, 64'h3000, 64'h0,  1'b1, 1'b1, LD,  1'b0, 1'b0, 64'h3000, 64'h0,  1'b0, AB,           1'b0, 1'b1, LD,    1'b0);
    vt[9]  = mk(1'b0, 64'h0,   1'b1, 1'b1, 64'h2000, 64'h55, 1'b0, 1'b0, RD2, 1'b0, 1'b0, 64'h3000, 64'h0,  1'b0, AB,           1'b0, 1'b0, LD,    1'b1);
    vt[10] = mk(1'b0, 64'h0,   1'b1, 1'b1, 64'h2000, 64'h55, 1'b0, 1'b1, RD2, 1'b1, 1'b1, 64'h2000, 64'h55, 1'b0, AB,           1'b0, 1'b0, LD,    1'b1);
    vt[11] = mk(1'b0, 64'h0,   1'b1, 1'b1, 64'h2000, 64'h55, 1'b0, 1'b1, RD2, 1'b1, 1'b1, 64'h2000, 64'h55, 1'b0, AB,           1'b0, 1'b0, LD,    1'b1);
    vt[12] = mk(1'b0, 64'h0,   1'b1, 1'b1, 64'h2000, 64'h55, 1'b1, 1'b1, RD2, 1'b1, 1'b1, 64'h2000, 64'h55, 1'b0, AB,           1'b0, 1'b0, LD,    1'b1);
    vt[13] = mk(1'b0, 64'h0,   1'b1, 1'b1, 64'h2000, 64'h55, 1'b0, 1'b1, RD2, 1'b0, 1'b1, 64'h2000, 64'h55, 1'b0, AB,           1'b0, 1'b0, LD,    1'b1);
    vt[14] = mk(1'b0, 64'h0,   1'b1, 1'b1, 64'h2000, 64'h55, 1'b0, 1'b0, RD2, 1'b0, 1'b1, 64'h2000, 64'h55, 1'b0, AB,           1'b0, 1'b1, LD,    1'b0);
    vt[15] = mk(1'b0, 64'h0,   1'b0, 1'b0, 64'h0,    64'h0,  1'b0, 1'b0, RD2, 1'b0, 1'b1, 64'h2000, 64'h55, 1'b0, AB,           1'b0, 1'b0, LD,    1'b0);
    vt[16] = mk(1'b1, 64'h200, 1'b0, 1'b0, 64'h0,    64'h0,  1'b0, 1'b0, RD3, 1'b0, 1'b1, 64'h2000, 64'h55, 1'b0, AB,           1'b1, 1'b0, LD,    1'b0);
    vt[17] = mk(1'b1, 64'h200, 1'b0, 1'b0, 64'h0,    64'h0,  1'b1, 1'b0, RD3, 1'b1, 1'b0, 64'h200,  64'h0,  1'b0, AB,           1'b1, 1'b0, LD,    1'b0);
    vt[18] = mk(1'b0, 64'h0,   1'b0, 1'b0, 64'h0,    64'h0,  1'b0, 1'b0, RD3, 1'b0, 1'b0, 64'h200,  64'h0,  1'b0, AB,           1'b0, 1'b0, LD,    1'b0);
    vt[19] = mk(1'b0, 64'h0,   1'b0, 1'b0, 64'h0,    64'h0,  1'b0, 1'b1, RD3, 1'b0, 1'b0, 64'h200,  64'h0,  1'b0, AB,           1'b0, 1'b0, LD,    1'b0);
    vt[20] = mk(1'b0, 64'h0,   1'b0, 1'b0, 64'h0,    64'h0,  1'b0, 1'b1, RD3, 1'b0, 1'b0, 64'h200,  64'h0,  1'b1, 32'h89AB_CDEF, 1'b0, 1'b0, LD,    1'b0);

    // Reset state
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 21; k++) begin
      drive(vt[k].i_req, vt[k].i_addr, vt[k].d_req, vt[k].d_wen, vt[k].d_addr,
            vt[k].d_wdata, vt[k].rdy, vt[k].rv, vt[k].rdata);
      n_vec++;
      t = $sformatf("v%0d", k);
      chk({t, " m_req"},   m_req,   vt[k].e_m_req);
      chk({t, " m_wen"},   m_wen,   vt[k].e_m_wen);
      chk({t, " m_addr"},  m_addr,  vt[k].e_m_addr);
      chk({t, " m_wdata"}, m_wdata, vt[k].e_m_wdata);
      chk({t, " i_valid"}, i_valid, vt[k].e_i_valid);
      chk({t, " i_inst"},  i_inst,  vt[k].e_i_inst);
      chk({t, " i_stall"}, i_stall, vt[k].e_i_stall);
      chk({t, " d_valid"}, d_valid, vt[k].e_d_valid);
      chk({t, " d_rdata"}, d_rdata, vt[k].e_d_rdata);
      chk({t, " d_stall"}, d_stall, vt[k].e_d_stall);
    end

    // Starvation: every round both ports conflict in IDLE. With a limit of 4,
    // IF wins after four consecutive D grants, and the count restarts from zero.
    for (int r = 0; r < 11; r++) begin
      logic exp_i;
      exp_i = (r == 4) || (r == 9);
      t = $sformatf("starve r%0d", r);
      drive(1'b1, 64'h1000, 1'b1, 1'b0, 64'h2000, 64'h0, 1'b1, 1'b1, RD0);
      drive(1'b1, 64'h1000, 1'b1, 1'b0, 64'h2000, 64'h0, 1'b1, 1'b1, RD0);
      n_vec++;
      chk({t, " m_req"}, m_req, 64'd1);
      chk({t, " grant addr"}, m_addr, exp_i ? 64'h1000 : 64'h2000);
      drive(1'b1, 64'h1000, 1'b1, 1'b0, 64'h2000, 64'h0, 1'b1, 1'b1, RD0);
      drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1, RD0);
      n_vec++;
      chk({t, " i_valid"}, i_valid, {63'd0, exp_i});
      chk({t, " d_valid"}, d_valid, {63'd0, ~exp_i});
    end

    // Completion masking: d_req stays high with the same address through the
    // valid cycle; only one memory request and one valid pulse may occur.
    nreq = 0;
    nval = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 64'h0, (c < 4) ? 1'b1 : 1'b0, 1'b0, 64'h4000, 64'h0, 1'b1, 1'b1, LD);
      if (m_req === 1'b1) nreq++;
      if (d_valid === 1'b1) nval++;
    end
    n_vec++;
    chk("mask m_req count", 64'(nreq), 64'd1);
    chk("mask d_valid count", 64'(nval), 64'd1);

    // Reset while in WAIT; a late response must be dropped.
    drive(1'b1, 64'h108, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, RD0);
    drive(1'b1, 64'h108, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, RD0);
    drive(1'b1, 64'h108, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, RD0);
    n_vec++;
    chk("pre-reset m_addr", m_addr, 64'h108);
    i_req = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero("async reset");
    ival = 0;
    drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, RD0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, RD0);
      if (i_valid === 1'b1 || d_valid === 1'b1 || m_req === 1'b1) ival++;
    end
    n_vec++;
    chk("post-reset activity", 64'(ival), 64'd0);
    chk_zero("post-reset");

`ifdef ARB_PERF_CNT_EN
    // A lone D access with 3 REQ and 3 WAIT cycles, then three conflicts.
    drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h10, 64'h0, 1'b0, 1'b0, LD);
    drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h10, 64'h0, 1'b0, 1'b0, LD);
    drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h10, 64'h0, 1'b0, 1'b0, LD);
    drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h10, 64'h0, 1'b1, 1'b0, LD);
    drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h10, 64'h0, 1'b0, 1'b0, LD);
    drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h10, 64'h0, 1'b0, 1'b0, LD);
    drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h10, 64'h0, 1'b0, 1'b1, LD);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h10, 64'h0, 1'b0, 1'b0, LD);
    n_vec++;
    chk("perf wait 6", cnt_wait, 64'd6);
    chk("perf conflict 0", cnt_conflict, 64'd0);
    for (int r = 0; r < 3; r++) begin
      drive(1'b1, 64'h20, 1'b1, 1'b0, 64'h30, 64'h0, 1'b1, 1'b1, LD);
      drive(1'b1, 64'h20, 1'b1, 1'b0, 64'h30, 64'h0, 1'b1, 1'b1, LD);
      drive(1'b1, 64'h20, 1'b1, 1'b0, 64'h30, 64'h0, 1'b1, 1'b1, LD);
      drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, LD);
    end
    n_vec++;
    chk("perf conflict 3", cnt_conflict, 64'd3);
    chk("perf wait 12", cnt_wait, 64'd12);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
